button_debouncer_bank: RTL and testbench



---
 rtl/game_ctrl_pkg.sv | 34 +++
 rtl/button_debouncer_channel.sv | 152 +++++++++++++++
 rtl/button_debouncer_bank.sv | 43 ++++
 tb/tb_button_debouncer_bank.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_ctrl_pkg
//  Purpose  : Shared debouncer state encoding and default timing constants
//  Revision : 1.0  initial release
// ============================================================================
package game_ctrl_pkg;

    localparam int unsigned DB_STATE_W = 6;
    typedef logic [DB_STATE_W-1:0] db_state_t;

    localparam db_state_t DB_IDLE    = 6'b000001;
    localparam db_state_t DB_WQ      = 6'b000010;
    localparam db_state_t DB_SCEN_ST = 6'b000100;
    localparam db_state_t DB_HOLD    = 6'b001000;
    localparam db_state_t DB_REPEAT  = 6'b010000;
    localparam db_state_t DB_WFR     = 6'b100000;

    // Defaults assume a 100 MHz system clock.
    localparam int unsigned DEF_N_BTN           = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_HOLD_CYCLES     = 50000000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 10000000;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage : game_ctrl_pkg
`default_nettype wire

// File: rtl/button_debouncer_channel.sv
`default_nettype none
// ============================================================================
//  Module   : button_debouncer_channel
//  Purpose  : One button: 2-flop synchronizer, debounce/auto-repeat FSM, counter
//  Revision : 1.0  initial release
// ============================================================================
module button_debouncer_channel
    import game_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic dpb,
    output logic scen,
    output logic mcen,
    output logic ccen
);

    localparam int unsigned CNT_W =
        (max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) > 1) ?
        $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
            $error("button_debouncer_channel: timing parameters must each be >= 2");
        end
    endgenerate

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= DB_IDLE;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state
    always_comb begin
        s1_d    = btn_raw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DB_IDLE: begin
                if (s2_q) begin
                    state_d = DB_WQ;
                    cnt_d   = '0;
                end
            end
            DB_WQ: begin
                if (!s2_q) begin
                    state_d = DB_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = DB_SCEN_ST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DB_SCEN_ST: begin
                state_d = DB_HOLD;
                cnt_d   = '0;
            end
            DB_HOLD: begin
                if (!s2_q) begin
                    state_d = DB_WFR;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = DB_REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DB_REPEAT: begin
                if (!s2_q) begin
                    state_d = DB_WFR;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DB_WFR: begin
                // A re-press here is release bounce: resume holding, no new scen.
                if (s2_q) begin
                    state_d = DB_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = DB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore outputs
    always_comb begin
        dpb  = 1'b0;
        scen = 1'b0;
        mcen = 1'b0;
        ccen = 1'b0;
        case (state_q)
            DB_SCEN_ST: begin
                dpb  = 1'b1;
                scen = 1'b1;
                mcen = 1'b1;
            end
            DB_HOLD: begin
                dpb = 1'b1;
            end
            DB_REPEAT: begin
                dpb  = 1'b1;
                ccen = 1'b1;
                mcen = (cnt_q == REP_LAST);
            end
            DB_WFR: begin
                dpb = 1'b1;
            end
            default: begin
                dpb = 1'b0;
            end
        endcase
    end

endmodule : button_debouncer_channel
`default_nettype wire

// File: rtl/button_debouncer_bank.sv
`default_nettype none
// ============================================================================
//  Module   : button_debouncer_bank
//  Purpose  : N independent debounced buttons with single/multi/continuous enables
//  Revision : 1.0  initial release
// ============================================================================
module button_debouncer_bank
    import game_ctrl_pkg::*;
#(
    parameter int unsigned N_BTN           = DEF_N_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] dpb,
    output logic [N_BTN-1:0] scen,
    output logic [N_BTN-1:0] mcen,
    output logic [N_BTN-1:0] ccen
);

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_chan
            button_debouncer_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .HOLD_CYCLES     (HOLD_CYCLES),
                .REPEAT_CYCLES   (REPEAT_CYCLES)
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .btn_raw (btn_raw[i]),
                .dpb     (dpb[i]),
                .scen    (scen[i]),
                .mcen    (mcen[i]),
                .ccen    (ccen[i])
            );
        end
    endgenerate

endmodule : button_debouncer_bank
`default_nettype wire

// File: tb/tb_button_debouncer_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_debouncer_bank
//  Purpose  : Self-checking bench for button_debouncer_bank (D=4, H=8, R=3)
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_debouncer_bank;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_raw;
    logic [N-1:0] dpb, scen, mcen, ccen;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         rst;
        logic [N-1:0] btn;
        logic [N-1:0] dpb;
        logic [N-1:0] scen;
        logic [N-1:0] mcen;
        logic [N-1:0] ccen;
    } vec_t;

    vec_t vecs[64];
    int   n_vec = 0;

    button_debouncer_bank #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .REPEAT_CYCLES   (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .dpb     (dpb),
        .scen    (scen),
        .mcen    (mcen),
        .ccen    (ccen)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [4*N-1:0] act, input logic [4*N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] {dpb,scen,mcen,ccen} got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [N-1:0] b, input logic [N-1:0] d,
                       input logic [N-1:0] s, input logic [N-1:0] m, input logic [N-1:0] c);
        vecs[n_vec] = '{rst: rst, btn: b, dpb: d, scen: s, mcen: m, ccen: c};
        n_vec++;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        btn_raw = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [N-1:0] ed, es, em, ec;

    initial begin
        reset   = 1'b1;
        btn_raw = 4'b1111;
        tick();
        tick();
        tick();
        check("reset_state", 0, {dpb, scen, mcen, ccen}, '0);

        // Clean press on ch0 for 10 cycles, release, debounce out at edge 16
        for (int e = 0; e < 18; e++)
            add(1'b0, (e < 10) ? 4'b0001 : 4'b0000,
                {3'b0, (e >= 6 && e <= 15)}, {3'b0, (e == 6)}, {3'b0, (e == 6)}, 4'b0000);
        add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Short 3-cycle pulse: nothing may assert
        for (int e = 0; e < 10; e++)
            add(1'b0, (e < 3) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Simultaneous press on ch1 and ch3
        for (int e = 0; e < 10; e++)
            add(1'b0, 4'b1010, (e >= 6) ? 4'b1010 : 4'b0000,
                (e == 6) ? 4'b1010 : 4'b0000, (e == 6) ? 4'b1010 : 4'b0000, 4'b0000);

        reset = 1'b1;
        btn_raw = '0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < n_vec; i++) begin
            reset   = vecs[i].rst;
            btn_raw = vecs[i].btn;
            tick();
            check("table", i, {dpb, scen, mcen, ccen},
                  {vecs[i].dpb, vecs[i].scen, vecs[i].mcen, vecs[i].ccen});
        end

        // Long hold into auto-repeat, release at edge 31
        do_reset();
        for (int e = 0; e < 40; e++) begin
            btn_raw = (e < 31) ? 4'b0001 : 4'b0000;
            tick();
            ed = {3'b0, (e >= 6 && e <= 36)};
            es = {3'b0, (e == 6)};
            em = {3'b0, (e == 6) || (e >= 17 && e <= 32 && ((e - 17) % 3) == 0)};
            ec = {3'b0, (e >= 15 && e <= 32)};
            check("long_hold", e, {dpb, scen, mcen, ccen}, {ed, es, em, ec});
        end

        // 2-cycle low glitch while held: hold timing restarts, REPEAT at edge 22
        do_reset();
        for (int e = 0; e < 31; e++) begin
            btn_raw = (e == 10 || e == 11) ? 4'b0000 : 4'b0001;
            tick();
            ed = {3'b0, (e >= 6)};
            es = {3'b0, (e == 6)};
            em = {3'b0, (e == 6) || (e >= 24 && ((e - 24) % 3) == 0)};
            ec = {3'b0, (e >= 22)};
            check("glitch", e, {dpb, scen, mcen, ccen}, {ed, es, em, ec});
        end

        // Reset mid-debounce (edge 4) and mid-hold (edge 15) with button held
        do_reset();
        for (int e = 0; e < 17; e++) begin
            btn_raw = 4'b0001;
            reset   = (e == 4 || e == 15);
            tick();
            ed = {3'b0, (e >= 11 && e <= 14)};
            es = {3'b0, (e == 11)};
            check("reset_press", e, {dpb, scen, mcen, 4'b0000}, {ed, es, es, 4'b0000});
            check("reset_ccen", e, {12'b0, ccen}, '0);
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_button_debouncer_bank
`default_nettype wire
